sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO: next generation of the team FIFO family.

---
 rtl/sync_fifo_param_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 23 ++
 rtl/sync_fifo_param.sv | 93 +++++++++
 tb/tb_sync_fifo_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO family.
package sync_fifo_param_pkg;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  function automatic int unsigned fifo_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int unsigned data_width = 8,
  parameter int unsigned fifo_depth = 32,
  parameter int unsigned addr_width = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [fifo_depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard/FWFT read mode, occupancy count, almost flags
// and one-cycle overflow/underflow pulses.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned data_width = 8,
  parameter int unsigned fifo_depth = 32,
  parameter int unsigned addr_width = fifo_log2(fifo_depth),
  parameter int unsigned fwft       = 0,
  parameter int unsigned af_thresh  = fifo_depth - 2,
  parameter int unsigned ae_thresh  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = addr_width + 1;
  localparam rd_mode_e    RD_MODE = (fwft != 0) ? RD_FWFT : RD_STANDARD;

  if (!is_pow2(fifo_depth) || fifo_depth < 4) begin : g_bad_depth
    $error("sync_fifo_param: fifo_depth must be a power of two >= 4");
  end
  if (!(ae_thresh < af_thresh && af_thresh <= fifo_depth)) begin : g_bad_thresh
    $error("sync_fifo_param: require ae_thresh < af_thresh <= fifo_depth");
  end

  logic [addr_width:0]   wr_ptr;
  logic [addr_width:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [data_width-1:0] rd_data;

  // Flags depend only on registered pointers, so request inputs never reach outputs.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]) &&
                        (wr_ptr[addr_width] != rd_ptr[addr_width]);
  assign almost_full  = (count >= PW'(af_thresh));
  assign almost_empty = (count <= PW'(ae_thresh));

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  fifo_ram #(
    .data_width (data_width),
    .fifo_depth (fifo_depth),
    .addr_width (addr_width)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[addr_width-1:0]),
    .wdata (din),
    .raddr (rd_ptr[addr_width-1:0]),
    .rdata (rd_data)
  );

  if (RD_MODE == RD_FWFT) begin : g_fwft
    assign dout = rd_data;
  end else begin : g_std
    logic [data_width-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param (depth 8), standard and FWFT instances.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] f_count;

  always #5 clk = ~clk;

  sync_fifo_param #(.data_width(8), .fifo_depth(DEPTH), .fwft(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow));

  sync_fifo_param #(.data_width(8), .fifo_depth(DEPTH), .fwft(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .din(f_din), .rd_en(f_rd), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf));

  typedef struct {
    int   cnt;
    logic full, empty, af, ae, ovf, unf;
    int   dout;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   model_q[$];
  int   data_q[$];
  exp_t flag_q[$];
  int   last_dout = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle on the standard instance; the model follows the FIFO rules directly.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    exp_t e;
    bit   pre_full, pre_empty;
    @(negedge clk);
    wr_en = w; rd_en = r; din = d;
    pre_full  = (model_q.size() == DEPTH);
    pre_empty = (model_q.size() == 0);
    e.ovf = w && pre_full;
    e.unf = r && pre_empty;
    if (r && !pre_empty) begin
      last_dout = model_q.pop_front();
      data_q.push_back(last_dout);
    end
    if (w && !pre_full) model_q.push_back(int'(d));
    e.cnt   = model_q.size();
    e.full  = (e.cnt == DEPTH);
    e.empty = (e.cnt == 0);
    e.af    = (e.cnt >= AF);
    e.ae    = (e.cnt <= AE);
    e.dout  = last_dout;
    flag_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   d;
    #1;
    if (flag_q.size() > 0) begin
      e = flag_q.pop_front();
      check("count", int'(count), e.cnt);
      check("full", int'(full), int'(e.full));
      check("empty", int'(empty), int'(e.empty));
      check("almost_full", int'(almost_full), int'(e.af));
      check("almost_empty", int'(almost_empty), int'(e.ae));
      check("overflow", int'(overflow), int'(e.ovf));
      check("underflow", int'(underflow), int'(e.unf));
      check("dout_hold", int'(dout), e.dout);
    end
    while (data_q.size() > 0) begin
      d = data_q.pop_front();
      check("rd_data", int'(dout), d);
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_empty"}, int'(empty), 1);
    check({tag, "_almost_empty"}, int'(almost_empty), 1);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_almost_full"}, int'(almost_full), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_underflow"}, int'(underflow), 0);
    check({tag, "_dout"}, int'(dout), 0);
  endtask

  initial begin
    int fq[$];
    int v;
    int wp, rp;

    #1;
    check_reset_state("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Fill past full, then drain in order.
    for (int i = 1; i <= DEPTH + 1; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);

    // Underflow on empty, including a write in the same cycle.
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h3C);
    cycle(1'b0, 1'b1, 8'h00);

    // Simultaneous traffic at count 4, then at full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'hEE);
    cycle(1'b0, 1'b0, 8'h00);

    // Random-rate traffic across many pointer wraps.
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 3)
        0: begin wp = 75; rp = 30; end
        1: begin wp = 30; rp = 75; end
        default: begin wp = 55; rp = 55; end
      endcase
      for (int i = 0; i < 40; i++)
        cycle(($urandom_range(99) < wp), ($urandom_range(99) < rp), 8'($urandom));
    end
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 8'h00);

    // Asynchronous reset with 5 entries held.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    model_q.delete();
    last_dout = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // FWFT instance: write shows up on dout one edge later, rd_en pops it.
    @(negedge clk);
    f_wr = 1'b1; f_din = 8'hA5;
    @(negedge clk);
    f_wr = 1'b0;
    check("fwft_empty_after_wr", int'(f_empty), 0);
    check("fwft_dout_shown", int'(f_dout), 8'hA5);
    check("fwft_count", int'(f_count), 1);
    f_rd = 1'b1;
    @(negedge clk);
    f_rd = 1'b0;
    check("fwft_empty_after_pop", int'(f_empty), 1);
    check("fwft_count_after_pop", int'(f_count), 0);
    for (int i = 0; i < 3; i++) begin
      v = int'($urandom_range(255));
      fq.push_back(v);
      f_wr = 1'b1; f_din = 8'(v);
      @(negedge clk);
    end
    f_wr = 1'b0;
    while (fq.size() > 0) begin
      v = fq.pop_front();
      check("fwft_head", int'(f_dout), v);
      f_rd = 1'b1;
      @(negedge clk);
    end
    f_rd = 1'b0;
    check("fwft_drained", int'(f_empty), 1);
    f_rd = 1'b1;
    @(negedge clk);
    f_rd = 1'b0;
    check("fwft_underflow", int'(f_unf), 1);

    @(posedge clk); #2;
    if (flag_q.size() != 0 || data_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", flag_q.size() + data_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
